// File: rtl/vram_write_fifo.sv
// vram_write_fifo: captures Z80 VRAM writes into a small FIFO drained by a req/ack consumer
module vram_write_fifo #(
  parameter int   DEPTH   = 4,
  parameter logic ADDR_HI = 1'b1
) (
  input  logic                   CLK_50,
  input  logic                   nRST,
  input  logic [15:0]            CPU_A,
  input  logic [7:0]             CPU_D,
  input  logic                   CPU_nWR,
  input  logic                   CPU_nMREQ,
  output logic                   CPU_nWAIT,
  output logic                   WR_REQ,
  output logic [14:0]            WR_ADDR,
  output logic [7:0]             WR_DATA,
  input  logic                   WR_ACK,
  output logic [$clog2(DEPTH):0] COUNT,
  output logic                   OVF,
  input  logic                   CLR_OVF
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [CW-1:0] NEAR = CW'(DEPTH - 1);
  logic          s1, s2, s3;
  logic [23:0]   hold;
  logic [22:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr, rd_nxt;
  logic [CW-1:0] count_nxt;
  logic [22:0]   head_nxt;
  logic          commit, push_req, push, pop, drop;
  // commit on the strobe's rising edge; a push into a full queue only succeeds when a pop frees a slot
  always_comb begin
    commit    = s2 & ~s3;
    push_req  = commit && (hold[23] == ADDR_HI);
    pop       = WR_ACK && (COUNT != '0);
    push      = push_req && ((COUNT < FULL) || pop);
    drop      = push_req && !push;
    rd_nxt    = pop ? rd_ptr + PW'(1) : rd_ptr;
    count_nxt = push ? (pop ? COUNT : COUNT + CW'(1)) : (pop ? COUNT - CW'(1) : COUNT);
    head_nxt  = (push && wr_ptr == rd_nxt) ? hold[22:0] : mem[rd_nxt];
  end
  // bus snapshot while the strobe is low, and queue storage; neither needs a reset
  always_ff @(posedge CLK_50) begin
    if (!s1) hold <= {CPU_A, CPU_D};
    if (push) mem[wr_ptr] <= hold[22:0];
  end
  // strobe synchronizer, pointers, registered head/status outputs
  always_ff @(posedge CLK_50 or negedge nRST) begin
    if (!nRST) begin
      {s1, s2, s3} <= 3'b111;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      COUNT        <= '0;
      WR_REQ       <= 1'b0;
      WR_ADDR      <= '0;
      WR_DATA      <= '0;
      OVF          <= 1'b0;
      CPU_nWAIT    <= 1'b1;
    end else begin
      {s1, s2, s3} <= {CPU_nWR & CPU_nMREQ, s1, s2};
      wr_ptr       <= push ? wr_ptr + PW'(1) : wr_ptr;
      rd_ptr       <= rd_nxt;
      COUNT        <= count_nxt;
      WR_REQ       <= count_nxt != '0;
      {WR_ADDR, WR_DATA} <= (count_nxt != '0) ? head_nxt : {WR_ADDR, WR_DATA};
      OVF          <= drop ? 1'b1 : (CLR_OVF ? 1'b0 : OVF);
      CPU_nWAIT    <= COUNT < NEAR;
    end
  end
endmodule

// File: doc/vram_write_fifo.md
Name: vram_write_fifo

Overview:
- Upstream stage of the 80x30 text VGA controller.
- Captures asynchronous Z80 memory writes aimed at video RAM and queues them in a small FIFO.
- Presents queued writes to the video controller through a request/acknowledge handshake, so the controller can retire them in its RAM write slot without sampling the raw CPU bus.
- Throttles the CPU with a WAIT output when the queue nears full.

Parameters:
- DEPTH, 4, FIFO entries; power of two, 2..16.
- ADDR_HI, 1'b1, required value of CPU_A[15] for a write to be accepted as a VRAM write.

Ports:
- CLK_50  in  1  system clock, 50 MHz.
- nRST  in  1  asynchronous active-low reset.
- CPU_A  in  16  Z80 address bus; asynchronous to CLK_50.
- CPU_D  in  8  Z80 data bus; input only.
- CPU_nWR  in  1  Z80 write strobe, active low; asynchronous.
- CPU_nMREQ  in  1  Z80 memory request, active low; asynchronous.
- CPU_nWAIT  out  1  Z80 wait request, active low.
- WR_REQ  out  1  high while at least one entry is queued.
- WR_ADDR  out  15  VRAM address of the head entry.
- WR_DATA  out  8  data of the head entry.
- WR_ACK  in  1  one-clock pulse from the consumer: head entry written, pop it.
- COUNT  out  $clog2(DEPTH)+1  current number of queued entries.
- OVF  out  1  sticky overflow flag.
- CLR_OVF  in  1  synchronous clear of OVF.

Behaviour:
- Clocking and reset:
  - Single clock CLK_50; reset is asynchronous and active-low on nRST.
  - All state is in the CLK_50 domain.
- Reset values:
  - Synchronizer stages = 1 (idle).
  - Pointers = 0, COUNT = 0, WR_REQ = 0, OVF = 0, CPU_nWAIT = 1.
  - WR_ADDR/WR_DATA = 0.
  - FIFO storage is not reset.
- Synchronizer:
  - CPU_nWR AND-ed with CPU_nMREQ as a combined active-low strobe `s`.
  - `s` passes through 3 flops: s1 → s2 → s3.
- Hold register:
  - Loads {CPU_A, CPU_D} on every clock in which s1 = 0.
  - Frozen otherwise.
  - Effect: holds the bus value sampled in the last cycle before the strobe deasserted at s1.
- Commit event:
  - Fires when s2 = 1 and s3 = 0, i.e. a rising edge of the strobe.
  - Latency: 3 clocks after CPU_nWR rises.
  - On commit, the write is pushed if hold A[15] == ADDR_HI; otherwise it is discarded silently.
  - Strobes shorter than one clock may be missed. This is acceptable: a Z80 write strobe is at least 1 T-state long, far longer than 20 ns.
- FIFO:
  - Circular buffer of DEPTH entries, each {A[14:0], D[7:0]}.
  - Write and read pointers wrap modulo DEPTH.
  - COUNT ranges 0..DEPTH.
- Push:
  - Accepted if COUNT < DEPTH, or if a pop occurs in the same cycle.
  - When full with no pop: entry dropped, OVF set, COUNT unchanged.
- Pop:
  - Occurs on WR_ACK = 1 with COUNT > 0.
  - WR_ACK with COUNT = 0 is ignored, with no underflow.
- Simultaneous push and pop: COUNT unchanged; both pointers advance.
- Outputs:
  - WR_REQ = (COUNT != 0), registered.
  - WR_ADDR/WR_DATA show the head entry, registered.
  - The head entry is valid in the same cycle WR_REQ is high.
  - After a pop, the next entry, or WR_REQ = 0, appears on the following clock.
- Consumer contract: WR_ADDR/WR_DATA remain stable from the rise of WR_REQ until the cycle after WR_ACK.
- CPU_nWAIT:
  - Driven 0 when COUNT >= DEPTH-1.
  - Registered; 1-clock latency.
  - Releases to 1 when COUNT falls below DEPTH-1.
- OVF:
  - Set by a dropped push; held until CLR_OVF = 1.
  - CLR_OVF and a new overflow in the same cycle: OVF = 1 (set wins).
- Reset mid-operation:
  - Queue emptied, WR_REQ drops immediately (asynchronously).
  - A strobe that is low when reset releases is not committed until a full low→high sequence has been observed after reset.

Test Plan:
- Reset, then a single write to A = 16'h8123, D = 8'h5A with nWR low for 6 clocks
  -> 3 clocks after nWR rises: WR_REQ = 1, WR_ADDR = 15'h0123, WR_DATA = 8'h5A, COUNT = 1.
  -> Pulse WR_ACK: WR_REQ = 0 on the next clock.
- Write to A = 16'h4123 (A[15] = 0)
  -> no push: WR_REQ stays 0, COUNT = 0.
- 4 consecutive writes (D = 01..04) with WR_ACK held low
  -> CPU_nWAIT goes 0 after the 3rd commit, COUNT = 4.
  -> Drain with 4 ACKs: data order 01, 02, 03, 04; CPU_nWAIT returns to 1 when COUNT = 2.
- Full FIFO with a 5th write (D = 05) committed without ACK
  -> OVF = 1, COUNT = 4, entry 05 absent on drain.
  -> CLR_OVF pulse: OVF = 0.
- Full FIFO with a commit landing in the same cycle as WR_ACK
  -> no overflow, COUNT stays 4, new entry appears last in drain order.
- Assert nRST while COUNT = 2 and nWR low
  -> WR_REQ = 0, COUNT = 0, CPU_nWAIT = 1 immediately.
  -> nWR rising after reset release with s1..s3 still 1: no commit.
